// File: rtl/subleq_ram_responder.sv
// subleq_ram_responder
// Memory-side responder for the subleq RAM bus. It accepts a request on a
// rising edge of i_ram_ctl while i_ram_ena is high, optionally inserts wait
// states, performs a single read or write on the internal word array, and
// then pulses o_ram_rdy for one cycle. Read data is registered onto
// o_dat_out, and o_dat_oe marks it valid while the transaction is in DONE.
//
// Optional feature, selected by the macro SUBLEQ_RAM_WPROT_EN:
//   when defined, writes to addresses below WPROT_TOP are dropped and are
//   flagged on o_ram_err alongside o_ram_rdy. When undefined, every write
//   lands and o_ram_err stays low.

module subleq_ram_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int WPROT_TOP   = 16
) (
    input  logic              i_clk,
    input  logic              i_res,
    input  logic              i_ram_ena,
    input  logic              i_ram_ope,
    input  logic              i_ram_ctl,
    input  logic [ADDR_W-1:0] i_adr_in,
    input  logic [DATA_W-1:0] i_dat_in,
    output logic [DATA_W-1:0] o_dat_out,
    output logic              o_dat_oe,
    output logic              o_ram_rdy,
    output logic              o_ram_busy,
    output logic              o_ram_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE
    } stateT;

    stateT             r_state;
    logic              r_ctlQ;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_adr;
    logic [DATA_W-1:0] r_dat;
    logic              r_ope;
    logic [DATA_W-1:0] r_datOut;
    logic              r_datOe;
    logic              r_rdy;
    logic              r_busy;
    logic              r_err;

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    logic w_accept;
    logic w_wrAllowed;
    logic w_wrEn;

`ifdef SUBLEQ_RAM_WPROT_EN
    localparam logic [ADDR_W:0] PROT_LIM = (ADDR_W + 1)'(WPROT_TOP);
    assign w_wrAllowed = ({1'b0, r_adr} >= PROT_LIM);
`else
    logic w_unusedProt;
    assign w_unusedProt = (WPROT_TOP != 0);
    assign w_wrAllowed  = 1'b1;
`endif

    // A fresh rising edge of the strobe with the chip enabled starts a transaction;
    // a strobe held high never retriggers because r_ctlQ follows it.
    assign w_accept = (r_state == ST_IDLE) & i_ram_ctl & ~r_ctlQ & i_ram_ena;

    // The array is only touched in ACCESS, so a reset or abort earlier in the
    // transaction can never corrupt memory.
    assign w_wrEn = (r_state == ST_ACCESS) & r_ope & w_wrAllowed;

    // Array write port; the array itself is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_wrEn) begin
            r_mem[r_adr] <= r_dat;
        end
    end

    // Access sequencer: IDLE -> [WAIT] -> ACCESS -> DONE -> IDLE, with all bus outputs registered.
    always_ff @(posedge i_clk or negedge i_res) begin
        if (!i_res) begin
            r_state  <= ST_IDLE;
            r_ctlQ   <= 1'b0;
            r_cnt    <= 4'd0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_ope    <= 1'b0;
            r_datOut <= '0;
            r_datOe  <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ctlQ <= i_ram_ctl;
            case (r_state)
                ST_IDLE: begin
                    r_datOe <= 1'b0;
                    r_rdy   <= 1'b0;
                    r_err   <= 1'b0;
                    if (w_accept) begin
                        r_adr  <= i_adr_in;
                        r_dat  <= i_dat_in;
                        r_ope  <= i_ram_ope;
                        r_busy <= 1'b1;
                        r_cnt  <= 4'(WAIT_CYCLES);
                        r_state <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    if (!i_ram_ena) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt <= 4'd1) begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    if (!r_ope) begin
                        r_datOut <= r_mem[r_adr];
                    end
                    r_datOe <= ~r_ope;
                    r_rdy   <= 1'b1;
                    r_err   <= r_ope & ~w_wrAllowed;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_datOe <= 1'b0;
                    r_rdy   <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_dat_out  = r_datOut;
    assign o_dat_oe   = r_datOe;
    assign o_ram_rdy  = r_rdy;
    assign o_ram_busy = r_busy;
    assign o_ram_err  = r_err;

endmodule
